// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
// Used by mem_access_unit and data_memory; build option MEM_WAIT_EN.
package mem_access_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mau_state_t;

    localparam word_t MAU_MEM_BASE        = 32'd1024;
    localparam int    MAU_DEF_MEM_DEPTH   = 64;
    localparam int    MAU_DEF_WAIT_CYCLES = 3;

endpackage

// File: rtl/mem_access_unit_data_memory.sv
// Word-addressed data memory: combinational read, synchronous write.
// Out-of-range indices read as zero and never write.
module data_memory
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_DEPTH = MAU_DEF_MEM_DEPTH
) (
    input  logic        clk,
    input  logic        w_en,
    input  logic [31:0] idx,
    input  word_t       w_data,
    output word_t       r_data
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    word_t mem [MEM_DEPTH];
    logic  in_range;

    assign in_range = (idx < 32'(MEM_DEPTH));

    always_ff @(posedge clk) begin
        if (w_en && in_range) begin
            mem[idx[AW-1:0]] <= w_data;
        end
    end

    assign r_data = in_range ? mem[idx[AW-1:0]] : '0;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage with optional multi-cycle memory stall.
// Define MEM_WAIT_EN to build the IDLE/WAIT/DONE stall FSM; otherwise ready is tied high.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int    MEM_DEPTH   = MAU_DEF_MEM_DEPTH,
    parameter int    WAIT_CYCLES = MAU_DEF_WAIT_CYCLES,
    parameter word_t MEM_BASE    = MAU_MEM_BASE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exe_wb_en,
    input  logic       exe_mem_r_en,
    input  logic       exe_mem_w_en,
    input  word_t      exe_alu_res,
    input  word_t      exe_st_val,
    input  logic [3:0] exe_dest,
    output logic       ready,
    output logic       wb_wb_en,
    output logic       wb_mem_r_en,
    output word_t      wb_alu_res,
    output word_t      wb_mem_data,
    output logic [3:0] wb_dest,
    output mau_state_t dbg_state
);

    // Handshake: the exe_* instruction is consumed at the rising edge ending a
    // cycle with ready=1; while ready=0 upstream holds exe_* stable.
    logic [31:0] word_idx;
    word_t       rd_data;
    logic        mem_we;

    assign word_idx = (exe_alu_res - MEM_BASE) >> 2;
    assign mem_we   = ready & exe_mem_w_en & ~rst;

    data_memory #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .w_en  (mem_we),
        .idx   (word_idx),
        .w_data(exe_st_val),
        .r_data(rd_data)
    );

`ifdef MEM_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic          access;
    mau_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign access    = exe_mem_r_en | exe_mem_w_en;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter includes the accepting IDLE cycle, so IDLE plus WAIT spans
    // exactly WAIT_CYCLES stalled cycles before DONE releases the instruction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = ~access | (WAIT_CYCLES == 0);
                if (access && (WAIT_CYCLES > 0)) begin
                    if (WAIT_CYCLES == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q >= CW'(WAIT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end
`else
    assign ready     = 1'b1;
    assign dbg_state = ST_IDLE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wb_en    <= 1'b0;
            wb_mem_r_en <= 1'b0;
            wb_alu_res  <= '0;
            wb_mem_data <= '0;
            wb_dest     <= '0;
        end else if (ready) begin
            wb_wb_en    <= exe_wb_en;
            wb_mem_r_en <= exe_mem_r_en;
            wb_alu_res  <= exe_alu_res;
            wb_mem_data <= rd_data;
            wb_dest     <= exe_dest;
        end else begin
            wb_wb_en    <= 1'b0;
            wb_mem_r_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against an instruction-level model.
// Works with or without MEM_WAIT_EN defined.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int          DEPTH = 64;
    localparam int          WC    = 3;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          AW    = $clog2(DEPTH);
`ifdef MEM_WAIT_EN
    localparam int STALL = WC;
`else
    localparam int STALL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       exe_wb_en, exe_mem_r_en, exe_mem_w_en;
    logic [31:0] exe_alu_res, exe_st_val;
    logic [3:0] exe_dest;
    logic       ready, wb_wb_en, wb_mem_r_en;
    logic [31:0] wb_alu_res, wb_mem_data;
    logic [3:0] wb_dest;
    mau_state_t dbg_state;

    logic [31:0] exp_mem [DEPTH];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    mem_access_unit #(
        .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WC), .MEM_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
        .exe_alu_res(exe_alu_res), .exe_st_val(exe_st_val), .exe_dest(exe_dest),
        .ready(ready), .wb_wb_en(wb_wb_en), .wb_mem_r_en(wb_mem_r_en),
        .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data), .wb_dest(wb_dest),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic w, input logic wbe,
                         input logic [31:0] alu, input logic [31:0] st, input logic [3:0] dest);
        exe_mem_r_en = r;
        exe_mem_w_en = w;
        exe_wb_en    = wbe;
        exe_alu_res  = alu;
        exe_st_val   = st;
        exe_dest     = dest;
    endtask

    // Issues one instruction and follows it to writeback; called just after an edge.
    task automatic issue(input logic r, input logic w, input logic wbe,
                         input logic [31:0] alu, input logic [31:0] st,
                         input logic [3:0] dest, input string tag);
        logic [31:0] idx;
        logic        inr;
        logic [31:0] exp_data;
        int          stall;
        stall = (r | w) ? STALL : 0;
        idx   = (alu - BASE) >> 2;
        inr   = (idx < DEPTH);
        exp_q.push_back(inr ? exp_mem[idx[AW-1:0]] : 32'h0);
        drive(r, w, wbe, alu, st, dest);
        for (int c = 0; c <= stall; c++) begin
            checks++;
            if (ready !== (c == stall)) begin
                errors++;
                $display("FAIL %s ready cycle %0d: got %b want %b", tag, c, ready, (c == stall));
            end
            @(posedge clk); #1;
            if (c < stall) begin
                checks++;
                if (wb_wb_en !== 1'b0 || wb_mem_r_en !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bubble edge %0d: wb_en=%b r_en=%b want 0 0", tag, c + 1, wb_wb_en, wb_mem_r_en);
                end
            end
        end
        exp_data = exp_q.pop_front();
        checks++;
        if (wb_wb_en !== wbe || wb_mem_r_en !== r || wb_alu_res !== alu ||
            wb_dest !== dest || wb_mem_data !== exp_data) begin
            errors++;
            $display("FAIL %s wb: got en=%b r=%b alu=%h dest=%0d data=%h want en=%b r=%b alu=%h dest=%0d data=%h",
                     tag, wb_wb_en, wb_mem_r_en, wb_alu_res, wb_dest, wb_mem_data,
                     wbe, r, alu, dest, exp_data);
        end
        if (w && inr) exp_mem[idx[AW-1:0]] = st;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (wb_wb_en !== 0 || wb_mem_r_en !== 0 || wb_alu_res !== 0 || wb_mem_data !== 0 ||
            wb_dest !== 0 || ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset: en=%b r=%b alu=%h data=%h dest=%0d ready=%b st=%0d want all 0, ready 1, idle",
                     wb_wb_en, wb_mem_r_en, wb_alu_res, wb_mem_data, wb_dest, ready, dbg_state);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
        for (int i = 0; i < DEPTH; i++) issue(0, 1, 0, BASE + 32'(4 * i), 32'h0, 4'd0, "fill");
    endtask

    task automatic test_store_load();
        issue(0, 1, 0, 32'd1028, 32'hDEADBEEF, 4'd0, "store_1028");
        issue(1, 0, 1, 32'd1028, 32'h0, 4'd5, "load_1028");
        checks++;
        if (wb_mem_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_1028 data: got %h want deadbeef", wb_mem_data);
        end
    endtask

    task automatic test_pass_through();
        issue(0, 0, 1, 32'h7, 32'h0, 4'd3, "alu_pass");
        checks++;
        if (wb_alu_res !== 32'h7 || wb_wb_en !== 1'b1) begin
            errors++;
            $display("FAIL alu_pass: got alu=%h en=%b want 7 1", wb_alu_res, wb_wb_en);
        end
    endtask

    task automatic test_out_of_range();
        issue(0, 1, 0, BASE + 32'(4 * (DEPTH - 1)), 32'hA5A5_0063, 4'd0, "oor_seed_top");
        issue(0, 1, 0, BASE, 32'h1111_0000, 4'd0, "oor_seed_zero");
        issue(1, 0, 1, 32'd1020, 32'h0, 4'd1, "oor_load_1020");
        issue(0, 1, 0, BASE + 32'(4 * DEPTH), 32'hBAD0_BAD0, 4'd0, "oor_store_end");
        issue(1, 0, 1, BASE, 32'h0, 4'd2, "oor_check_word0");
        issue(1, 0, 1, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'd2, "oor_check_top");
    endtask

    task automatic test_reset_mid_access();
        drive(0, 1, 0, 32'd1036, 32'hCAFEF00D, 4'd0);
`ifdef MEM_WAIT_EN
        repeat (2) @(posedge clk);
        #1;
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        checks++;
        if (dbg_state !== ST_IDLE || ready !== 1'b1 || wb_wb_en !== 0 || wb_mem_r_en !== 0 ||
            wb_alu_res !== 0 || wb_mem_data !== 0 || wb_dest !== 0) begin
            errors++;
            $display("FAIL reset_mid: st=%0d ready=%b en=%b r=%b alu=%h data=%h dest=%0d want idle, 1, zeros",
                     dbg_state, ready, wb_wb_en, wb_mem_r_en, wb_alu_res, wb_mem_data, wb_dest);
        end
        issue(1, 0, 1, 32'd1036, 32'h0, 4'd6, "reset_mid_word");
    endtask

    task automatic test_back_to_back();
        issue(0, 1, 0, 32'd1032, 32'h12345678, 4'd0, "b2b_store");
        issue(1, 0, 1, 32'd1032, 32'h0, 4'd7, "b2b_load");
        checks++;
        if (wb_mem_data !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_load data: got %h want 12345678", wb_mem_data);
        end
        issue(1, 1, 1, 32'd1032, 32'h0BADF00D, 4'd8, "b2b_rw_same");
        issue(1, 0, 1, 32'd1032, 32'h0, 4'd9, "b2b_after_rw");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0)
                addr = BASE - 32'(4 * $urandom_range(1, 4));
            else
                addr = BASE + 32'(4 * $urandom_range(0, DEPTH + 2)) + 32'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  addr, $urandom, 4'($urandom_range(0, 15)), "random");
        end
    endtask

    initial begin
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_fill();
        test_store_load();
        test_pass_through();
        test_out_of_range();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
